// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the DMEM port B arbiter.
// Read tags carry a fixed 3-bit channel id, which covers the 8-channel maximum.
package dmem_arb_pkg;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned TAG_CH_W = 3;

    function automatic int unsigned CH_ID_W(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
    } rd_tag_t;

endpackage

// File: rtl/dmem_portb_arbiter_rr_arbiter.sv
// Pointer-based one-hot grant over NUM_CH requesters with a per-channel mask.
// The pointer holds the most recent grant; round-robin search starts just past it.
module rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned  NUM_CH    = 2,
    parameter int unsigned  PRIO_MODE = 0,
    localparam int unsigned CH_W      = CH_ID_W(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grant_id,
    output logic [CH_W-1:0]   o_last
);

    logic [CH_W-1:0]   r_last;
    logic [NUM_CH-1:0] w_req;
    logic              w_found;

    assign w_req  = i_req & i_mask;
    assign o_last = r_last;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        if (PRIO_MODE == int'(PRIO_FIXED)) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!w_found && w_req[i]) begin
                    w_found    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_grant_id = CH_W'(i);
                end
            end
        end else begin
            // First pass: channels above the pointer; second pass wraps to the bottom.
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!w_found && w_req[i] && (i > int'(r_last))) begin
                    w_found    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_grant_id = CH_W'(i);
                end
            end
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!w_found && w_req[i]) begin
                    w_found    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_grant_id = CH_W'(i);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= CH_W'(NUM_CH - 1);
        end else if (i_advance) begin
            r_last <= o_grant_id;
        end
    end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Time-multiplexes NUM_CH requesters onto DMEM port B with burst locking,
// a one-cycle issue register and a read-tag pipeline that routes mem_q back.
module dmem_portb_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned  NUM_CH    = 2,
    parameter int unsigned  DATA_W    = 256,
    parameter int unsigned  ADDR_W    = 7,
    parameter int unsigned  RD_LAT    = 2,
    parameter int unsigned  PRIO_MODE = 0,
    localparam int unsigned CH_W      = CH_ID_W(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_req_valid,
    output logic [NUM_CH-1:0]        o_req_ready,
    input  logic [NUM_CH-1:0]        i_req_we,
    input  logic [NUM_CH-1:0]        i_req_lock,
    input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
    output logic [NUM_CH-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]        o_rsp_rdata,
    output logic [ADDR_W-1:0]        o_mem_address,
    output logic [DATA_W-1:0]        o_mem_data,
    output logic                     o_mem_wren,
    output logic                     o_mem_rden,
    input  logic [DATA_W-1:0]        i_mem_q,
    output logic [CH_W-1:0]          o_owner_id,
    output logic                     o_busy
);

    lock_state_e       r_state;
    lock_state_e       w_state_next;
    logic [NUM_CH-1:0] r_owner_oh;
    logic [NUM_CH-1:0] w_owner_oh_next;
    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_grant_id;
    logic              w_accept;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_owner_lock;
    logic              w_tag_busy;

    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_wren;
    logic              r_mem_rden;
    rd_tag_t           r_issue_tag;
    rd_tag_t           r_tag [RD_LAT];

    // While locked, only the recorded owner may be granted.
    assign w_mask = (r_state == ST_LOCKED) ? r_owner_oh : '1;

    rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_rr_arbiter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_valid),
        .i_mask     (w_mask),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_last     (o_owner_id)
    );

    assign o_req_ready  = w_grant;
    assign w_accept     = |w_grant;
    assign w_owner_lock = |(i_req_lock & r_owner_oh);

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (w_grant[i]) begin
                w_sel_we    = i_req_we[i];
                w_sel_lock  = i_req_lock[i];
                w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_oh_next = r_owner_oh;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_sel_lock) begin
                    w_state_next    = ST_LOCKED;
                    w_owner_oh_next = w_grant;
                end
            end
            ST_LOCKED: begin
                // Release as soon as the owner drops lock; its beat this cycle still issues.
                if (!w_owner_lock) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_owner_oh <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner_oh <= w_owner_oh_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
            r_mem_rden    <= 1'b0;
            r_issue_tag   <= '0;
        end else begin
            r_mem_wren        <= w_accept & w_sel_we;
            r_mem_rden        <= w_accept & ~w_sel_we;
            r_issue_tag.valid <= w_accept & ~w_sel_we;
            r_issue_tag.ch    <= TAG_CH_W'(w_grant_id);
            if (w_accept) begin
                r_mem_address <= w_sel_addr;
                r_mem_data    <= w_sel_wdata;
            end
        end
    end

    // Tag travels alongside mem_rden; the tail lines up with valid mem_q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= r_issue_tag;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            o_rsp_valid[i] = r_tag[RD_LAT-1].valid && (r_tag[RD_LAT-1].ch == TAG_CH_W'(i));
        end
    end

    always_comb begin
        w_tag_busy = r_issue_tag.valid;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_tag_busy = w_tag_busy | r_tag[i].valid;
        end
    end

    assign o_rsp_rdata   = i_mem_q;
    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_wren    = r_mem_wren;
    assign o_mem_rden    = r_mem_rden;
    assign o_busy        = (r_state == ST_LOCKED) | w_tag_busy;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Scoreboard bench for dmem_portb_arbiter: 3 channels, RD_LAT=2, with a RAM model
// and a fixed-priority twin fed the same requests.
module tb_dmem_portb_arbiter;

    localparam int unsigned NC = 3;
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 7;
    localparam int unsigned RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NC-1:0] valid, we, lock;
    logic [AW-1:0] addr  [NC];
    logic [DW-1:0] wdata [NC];
    logic [NC*AW-1:0] addr_p;
    logic [NC*DW-1:0] wdata_p;

    always_comb begin
        addr_p  = '0;
        wdata_p = '0;
        for (int i = 0; i < int'(NC); i++) begin
            addr_p[i*AW +: AW]  = addr[i];
            wdata_p[i*DW +: DW] = wdata[i];
        end
    end

    logic [NC-1:0] ready, rsp_valid, f_ready, f_rsp_valid;
    logic [DW-1:0] rsp_rdata, mem_data, mem_q, f_rsp_rdata, f_mem_data;
    logic [AW-1:0] mem_address, f_mem_address;
    logic          mem_wren, mem_rden, busy, f_mem_wren, f_mem_rden, f_busy;
    logic [1:0]    owner_id, f_owner_id;

    dmem_portb_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .PRIO_MODE(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready), .i_req_we(we),
        .i_req_lock(lock), .i_req_addr(addr_p), .i_req_wdata(wdata_p), .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata), .o_mem_address(mem_address), .o_mem_data(mem_data),
        .o_mem_wren(mem_wren), .o_mem_rden(mem_rden), .i_mem_q(mem_q), .o_owner_id(owner_id),
        .o_busy(busy)
    );

    dmem_portb_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .PRIO_MODE(1)) dut_fix (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(f_ready), .i_req_we(we),
        .i_req_lock(lock), .i_req_addr(addr_p), .i_req_wdata(wdata_p),
        .o_rsp_valid(f_rsp_valid), .o_rsp_rdata(f_rsp_rdata), .o_mem_address(f_mem_address),
        .o_mem_data(f_mem_data), .o_mem_wren(f_mem_wren), .o_mem_rden(f_mem_rden),
        .i_mem_q(mem_q), .o_owner_id(f_owner_id), .o_busy(f_busy)
    );

    // RAM model: q valid RL cycles after the rden cycle.
    logic [DW-1:0] ram    [128];
    logic [DW-1:0] shadow [128];
    logic [DW-1:0] q_pipe [RL];

    function automatic logic [DW-1:0] init_word(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(a);
        return {8{w}};
    endfunction

    initial begin
        for (int a = 0; a < 128; a++) begin
            ram[a]    = init_word(a);
            shadow[a] = init_word(a);
        end
        for (int i = 0; i < int'(RL); i++) q_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        q_pipe[0] <= mem_rden ? ram[mem_address] : '0;
        for (int i = 1; i < int'(RL); i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } iss_t;
    typedef struct {
        int            due;
        int            ch;
        logic [DW-1:0] data;
    } rsp_t;

    iss_t iss_q [$];
    rsp_t rsp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    iss_t mon_i;
    rsp_t mon_r;
    always @(negedge clk) begin
        if (!rst) begin
            if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                mon_i = iss_q.pop_front();
                check("iss_wren", DW'(mem_wren), DW'(mon_i.we));
                check("iss_rden", DW'(mem_rden), DW'(!mon_i.we));
                check("iss_addr", DW'(mem_address), DW'(mon_i.addr));
                if (mon_i.we) check("iss_data", mem_data, mon_i.data);
            end else if (mem_wren || mem_rden) begin
                check("iss_unexp", DW'({mem_wren, mem_rden}), '0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                mon_r = rsp_q.pop_front();
                check("rsp_valid", DW'(rsp_valid), DW'(1) << mon_r.ch);
                check("rsp_data", rsp_rdata, mon_r.data);
            end else if (rsp_valid != '0) begin
                check("rsp_unexp", DW'(rsp_valid), '0);
            end
        end
    end

    // One cycle: compare ready, record accepted beats, drop valid of accepted channels.
    task automatic step(input logic [NC-1:0] exp_rdy, input string tag);
        logic [NC-1:0] acc;
        iss_t          ie;
        rsp_t          re;
        @(negedge clk);
        check(tag, DW'(ready), DW'(exp_rdy));
        acc = valid & ready;
        for (int i = 0; i < int'(NC); i++) begin
            if (acc[i]) begin
                ie.due  = cyc + 1;
                ie.we   = we[i];
                ie.addr = addr[i];
                ie.data = wdata[i];
                iss_q.push_back(ie);
                if (we[i]) begin
                    shadow[addr[i]] = wdata[i];
                end else begin
                    re.due  = cyc + 1 + int'(RL);
                    re.ch   = i;
                    re.data = shadow[addr[i]];
                    rsp_q.push_back(re);
                end
            end
        end
        @(posedge clk);
        #1;
        valid = valid & ~acc;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, "idle_rdy");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, DW'(ready), '0);
        check({tag, "_wren"}, DW'(mem_wren), '0);
        check({tag, "_rden"}, DW'(mem_rden), '0);
        check({tag, "_addr"}, DW'(mem_address), '0);
        check({tag, "_data"}, mem_data, '0);
        check({tag, "_rspv"}, DW'(rsp_valid), '0);
        check({tag, "_rdata"}, rsp_rdata, mem_q);
        check({tag, "_owner"}, DW'(owner_id), DW'(NC - 1));
        check({tag, "_busy"}, DW'(busy), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        valid = '0;
        we    = '0;
        lock  = '0;
        for (int i = 0; i < int'(NC); i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_fix_owner", DW'(f_owner_id), DW'(NC - 1));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single write from ch0.
        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 7'h05; wdata[0] = 256'hA5;
        step(3'b001, "wr_rdy");
        idle(4);

        // Single read from ch1.
        valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 7'd3;
        step(3'b010, "rd_rdy");
        idle(4);

        // ch2 writes, then ch0 reads the same word back.
        valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 7'd20; wdata[2] = {8{32'h1234_5678}};
        step(3'b100, "wr2_rdy");
        idle(2);
        valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 7'd20;
        step(3'b001, "rb_rdy");
        idle(4);

        // Reset between accept and response.
        valid[2] = 1'b1; we[2] = 1'b0; addr[2] = 7'd40;
        step(3'b100, "rr_pre_rdy");
        check("busy_rd", DW'(busy), DW'(1));
        @(negedge clk);
        #1 rst = 1'b1;
        rsp_q.delete();
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        // All channels valid: round-robin rotates, fixed stays on ch0.
        for (int k = 0; k < 6; k++) begin
            valid = '1;
            we    = '0;
            for (int i = 0; i < int'(NC); i++) addr[i] = AW'(10 + i);
            #1 check("fix_rdy", DW'(f_ready), DW'(3'b001));
            step(NC'(1) << (k % 3), "rr_rdy");
        end
        valid = '0;
        idle(4);
        check("rr_owner", DW'(owner_id), DW'(2));

        // Locked burst from ch0 while ch1 waits.
        for (int k = 0; k < 4; k++) begin
            valid[0] = 1'b1; we[0] = 1'b1; lock[0] = (k < 3);
            addr[0]  = AW'(50 + k); wdata[0] = DW'(32'hBEEF_0000 + k);
            valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 7'd60;
            step(3'b001, "lock_rdy");
            if (k == 0) check("lock_busy", DW'(busy), DW'(1));
        end
        lock[0] = 1'b0;
        step(3'b010, "rel_rdy");
        idle(4);
        check("lock_owner", DW'(owner_id), DW'(1));

        for (int k = 0; k < 20 && (iss_q.size() > 0 || rsp_q.size() > 0); k++) idle(1);
        check("drain_iss", DW'(iss_q.size()), '0);
        check("drain_rsp", DW'(rsp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_portb_arbiter.md
# dmem_portb_arbiter

Parametrised arbiter for the shared DMEM port B. It time-multiplexes NUM_CH requesters onto the single RAM port: the CCD frame writer, the NN accelerator, and future DMA/SPART agents. Arbitration is round-robin or fixed-priority, with a lock to keep bursts contiguous. A read-tag pipeline routes RAM read data back to the requesting channel.

## Interface
Parameters:
- NUM_CH, 2: number of requester channels, 1..8.
- DATA_W, 256: RAM port B word width.
- ADDR_W, 7: RAM port B address width.
- RD_LAT, 2: cycles from mem_rden to valid mem_q, 1..4.
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority with channel 0 highest.

Ports:
- clk, in, 1: single clock for the block.
- rst, in, 1: reset, asynchronous and active-high.
- req_valid, in, NUM_CH: channel i has a request pending.
- req_ready, out, NUM_CH: request of channel i is accepted this cycle.
- req_we, in, NUM_CH: 1 = write, 0 = read, per channel.
- req_lock, in, NUM_CH: channel keeps ownership after the current beat.
- req_addr, in, NUM_CH*ADDR_W: packed addresses, channel i at [i*ADDR_W +: ADDR_W].
- req_wdata, in, NUM_CH*DATA_W: packed write data, packed the same way.
- rsp_valid, out, NUM_CH: read data for channel i is on rsp_rdata.
- rsp_rdata, out, DATA_W: read data, broadcast to all channels.
- mem_address, out, ADDR_W: to RAM address_b.
- mem_data, out, DATA_W: to RAM data_b.
- mem_wren, out, 1: to RAM wren_b.
- mem_rden, out, 1: to RAM rden_b.
- mem_q, in, DATA_W: from RAM q_b.
- owner_id, out, $clog2(NUM_CH) (min 1): channel granted most recently (debug).
- busy, out, 1: a lock is held or a read is in flight.

## Operation
- Handshake: a beat transfers when req_valid[i] && req_ready[i].
  - req_ready is one-hot or zero; it is combinational from req_valid, req_lock owner state and the arbitration pointer.
  - A requester holds valid, we, addr and wdata stable until ready.
- Round-robin mode:
  - Register last_grant resets to NUM_CH-1, so channel 0 wins first after reset.
  - The search starts at last_grant+1 and wraps modulo NUM_CH.
  - last_grant updates on every accepted beat.
- Fixed mode: the lowest-index valid channel wins; last_grant is still tracked for owner_id.
- Lock state machine, states IDLE and LOCKED:
  - IDLE to LOCKED on an accepted beat with req_lock=1. The owner is recorded.
  - In LOCKED, only the owner can receive ready; all other channels see ready=0.
  - LOCKED to IDLE on the first cycle the owner's req_lock=0, whether or not valid is high. That cycle's accepted owner beat still issues.
- Issue stage: the accepted beat registers into mem_address, mem_data, mem_wren and mem_rden for exactly one cycle. mem_wren and mem_rden are never both high.
- Read tag pipeline:
  - The channel id plus a valid bit shifts through RD_LAT stages, aligned with mem_rden.
  - At the tail, rsp_valid[id]=1 for one cycle and rsp_rdata=mem_q, passed through combinationally.
- Writes produce no response.
- Back-to-back reads from different channels return in issue order, one per cycle.

## Timing
- Throughput: one beat per cycle sustained, with no idle cycle between channels or on a lock release.
- Write: accepted in cycle t; mem_wren=1 in cycle t+1.
- Read: accepted in cycle t; mem_rden=1 in cycle t+1; rsp_valid in cycle t+1+RD_LAT.
- Reset values: req_ready=0 (no valid during reset), mem_*=0, rsp_valid=0, rsp_rdata follows mem_q, owner_id=NUM_CH-1, busy=0, state IDLE.
- Reset asserted mid-operation: the issue stage and tag pipeline clear, in-flight reads never raise rsp_valid, and the lock is dropped.
- Simultaneous valid on all channels: exactly one grant per cycle. Every valid channel is served within NUM_CH cycles in round-robin mode while no lock is held.
- NUM_CH=1: ready equals valid (lock permitting); the pointer logic degenerates without warnings.

## Structure
- Shared package dmem_arb_pkg holds:
  - prio_mode_e: PRIO_RR, PRIO_FIXED.
  - CH_ID_W(n) function: max(1, $clog2(n)).
  - rd_tag_t struct: valid, ch id.
- Sub-module rr_arbiter holds the pointer-based one-hot grant over NUM_CH with a mask input. It is reused by the lock logic, which masks out everything except the owner.
- The top level holds the lock state machine, the issue register and the tag shift register.

## Test plan
- Single write: ch0 writes addr 7'h05, data 256'hA5. The next cycle shows mem_wren=1, mem_address=5 and the data; no rsp_valid ever follows.
- Single read, RD_LAT=2: ch1 reads addr 3 accepted in cycle 10. mem_rden is high in cycle 11; rsp_valid[1] is high in cycle 13 with rsp_rdata=mem_q.
- Round-robin fairness, NUM_CH=3: all valid for 6 cycles gives grant order 0,1,2,0,1,2.
- Fixed mode, same stimulus: ch0 is granted all 6 cycles.
- Lock burst: ch0 sends 4 beats with lock=1,1,1,0 while ch1 stays valid. ch1 gets ready only in the cycle after the 4th beat.
- Reset between accept and response: a read accepted, then rst pulses before the response is due. No rsp_valid appears and all outputs return to reset values.
